// File: rtl/residual_add_ctrl.sv
// Sequencing controller for the 16-lane residual add stage: meters the shortcut
// and layer streams through the shortcut FIFO and regenerates the framing markers.
module residual_add_ctrl #(
  parameter int DEPTH   = 8,
  parameter int LEN_W   = 16,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             sc_valid,
  output logic             sc_ready,
  input  logic             layer_valid,
  output logic             layer_ready,
  output logic             fifo_wr_en,
  output logic             fifo_rd_en,
  output logic             out_valid,
  output logic             o_sof,
  output logic             o_eof,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] occupancy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   sc_cnt_q, sc_cnt_d;
  logic [LEN_W-1:0]   ly_cnt_q, ly_cnt_d;
  logic [CNT_W-1:0]   occ_q, occ_d;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [LATENCY-1:0] sof_q, sof_d;
  logic [LATENCY-1:0] eof_q, eof_d;
  logic [LEN_W-1:0]   len_last;
  logic               pipe_next_empty;

  assign len_last = len_q - LEN_W'(1);

  // In DRAIN nothing new is issued, so the pipe empties once every stage but the last is clear.
  always_comb begin
    pipe_next_empty = 1'b1;
    for (int i = 0; i < LATENCY - 1; i++) begin
      if (vld_q[i]) begin
        pipe_next_empty = 1'b0;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    sc_cnt_d    = sc_cnt_q;
    ly_cnt_d    = ly_cnt_q;
    occ_d       = occ_q;
    sc_ready    = 1'b0;
    layer_ready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && (frame_len != '0)) begin
          len_d    = frame_len;
          sc_cnt_d = '0;
          ly_cnt_d = '0;
          occ_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        busy        = 1'b1;
        sc_ready    = (occ_q < DEPTH_C) && (sc_cnt_q < len_q);
        layer_ready = (occ_q != '0) && (ly_cnt_q < len_q);
      end
      DRAIN: begin
        busy = 1'b1;
        if (pipe_next_empty) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    fifo_wr_en = sc_valid & sc_ready;
    fifo_rd_en = layer_valid & layer_ready;

    if (fifo_wr_en) begin
      sc_cnt_d = sc_cnt_q + LEN_W'(1);
    end
    if (fifo_rd_en) begin
      ly_cnt_d = ly_cnt_q + LEN_W'(1);
    end
    if (fifo_wr_en || fifo_rd_en) begin
      occ_d = occ_q + CNT_W'(fifo_wr_en) - CNT_W'(fifo_rd_en);
    end
    if (fifo_rd_en && (ly_cnt_q == len_last)) begin
      state_d = DRAIN;
    end
  end

  always_comb begin
    vld_d    = '0;
    sof_d    = '0;
    eof_d    = '0;
    vld_d[0] = fifo_rd_en;
    sof_d[0] = fifo_rd_en && (ly_cnt_q == '0);
    eof_d[0] = fifo_rd_en && (ly_cnt_q == len_last);
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      sof_d[i] = sof_q[i-1];
      eof_d[i] = eof_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      len_q    <= '0;
      sc_cnt_q <= '0;
      ly_cnt_q <= '0;
      occ_q    <= '0;
      vld_q    <= '0;
      sof_q    <= '0;
      eof_q    <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      sc_cnt_q <= sc_cnt_d;
      ly_cnt_q <= ly_cnt_d;
      occ_q    <= occ_d;
      vld_q    <= vld_d;
      sof_q    <= sof_d;
      eof_q    <= eof_d;
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign o_sof     = sof_q[LATENCY-1];
  assign o_eof     = eof_q[LATENCY-1];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_residual_add_ctrl.sv
// Scoreboard bench for residual_add_ctrl: frames push expected {sof,eof} beats and
// done pulses; a negedge monitor pops and compares whenever the DUT presents them.
module tb_residual_add_ctrl;

  localparam int DEPTH   = 8;
  localparam int LEN_W   = 16;
  localparam int LATENCY = 2;
  localparam int CNT_W   = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] frame_len;
  logic             sc_valid;
  logic             sc_ready;
  logic             layer_valid;
  logic             layer_ready;
  logic             fifo_wr_en;
  logic             fifo_rd_en;
  logic             out_valid;
  logic             o_sof;
  logic             o_eof;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] occupancy;

  residual_add_ctrl #(
    .DEPTH(DEPTH), .LEN_W(LEN_W), .LATENCY(LATENCY), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len),
    .sc_valid(sc_valid), .sc_ready(sc_ready),
    .layer_valid(layer_valid), .layer_ready(layer_ready),
    .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en),
    .out_valid(out_valid), .o_sof(o_sof), .o_eof(o_eof),
    .busy(busy), .done(done), .occupancy(occupancy)
  );

  // Packed view used by the cycle-exact tables:
  // {sc_ready, layer_ready, wr, rd, occupancy[3:0], out_valid, sof, eof, busy, done}
  logic [12:0] obs;
  assign obs = {sc_ready, layer_ready, fifo_wr_en, fifo_rd_en, occupancy,
                out_valid, o_sof, o_eof, busy, done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {logic sof; logic eof;} beat_t;
  beat_t exp_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int exp_done_total = 0;
  int done_seen   = 0;
  int wr_count    = 0;
  int rd_count    = 0;
  int out_count   = 0;
  int max_occ     = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Move to the next drive point, just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a start request; accepted frames queue their beats and one done pulse.
  task automatic applyStimulus(input int len, input logic accepted);
    start     = 1'b1;
    frame_len = LEN_W'(len);
    if (accepted) begin
      for (int i = 0; i < len; i++) begin
        exp_q.push_back('{sof: (i == 0), eof: (i == len - 1)});
      end
      exp_done_total++;
    end
  endtask

  // Drive one cycle of inputs and compare the packed outputs against a hand table row.
  task automatic doCycle(input string name, input logic s, input logic sv, input logic lv,
                         input logic [12:0] expected);
    start       = s;
    sc_valid    = sv;
    layer_valid = lv;
    #1;
    checkOutput(name, 32'(obs), 32'(expected));
    tick();
  endtask

  // Wait for done with a bounded cycle budget, then step to the next drive point.
  task automatic waitDone(input string name, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checkOutput(name, 32'(seen), 32'd1);
    tick();
  endtask

  // Scoreboard monitor: runs at the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_wr_en) wr_count++;
      if (fifo_rd_en) rd_count++;
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
      if (out_valid) begin
        beat_t b;
        out_count++;
        checkOutput("beat_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          b = exp_q.pop_front();
          checkOutput("beat_sof", 32'(o_sof), 32'(b.sof));
          checkOutput("beat_eof", 32'(o_eof), 32'(b.eof));
        end
      end
      if (done) begin
        checkOutput("done_expected", 32'(done_seen < exp_done_total), 32'd1);
        checkOutput("busy_low_at_done", 32'(busy), 32'd0);
        done_seen++;
      end
    end
  end

  initial begin
    int wr_base;
    int rd_base;
    int out_base;
    int n;

    rst_n       = 1'b0;
    start       = 1'b0;
    frame_len   = '0;
    sc_valid    = 1'b0;
    layer_valid = 1'b0;
    tick();
    #1;
    checkOutput("reset_state", 32'(obs), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Frame of 4: fill then drain, exact cycle table.
    applyStimulus(4, 1'b1);
    doCycle("t1_cyc0_idle",  1'b1, 1'b0, 1'b0, 13'b0_0_0_0_0000_0_0_0_0_0);
    doCycle("t1_cyc1_wr",    1'b0, 1'b1, 1'b0, 13'b1_0_1_0_0000_0_0_0_1_0);
    doCycle("t1_cyc2_wr",    1'b0, 1'b1, 1'b0, 13'b1_1_1_0_0001_0_0_0_1_0);
    doCycle("t1_cyc3_wr",    1'b0, 1'b1, 1'b0, 13'b1_1_1_0_0010_0_0_0_1_0);
    doCycle("t1_cyc4_wr",    1'b0, 1'b1, 1'b0, 13'b1_1_1_0_0011_0_0_0_1_0);
    doCycle("t1_cyc5_rd",    1'b0, 1'b0, 1'b1, 13'b0_1_0_1_0100_0_0_0_1_0);
    doCycle("t1_cyc6_rd",    1'b0, 1'b0, 1'b1, 13'b0_1_0_1_0011_0_0_0_1_0);
    doCycle("t1_cyc7_sof",   1'b0, 1'b0, 1'b1, 13'b0_1_0_1_0010_1_1_0_1_0);
    doCycle("t1_cyc8_rd",    1'b0, 1'b0, 1'b1, 13'b0_1_0_1_0001_1_0_0_1_0);
    doCycle("t1_cyc9_drain", 1'b0, 1'b0, 1'b0, 13'b0_0_0_0_0000_1_0_0_1_0);
    doCycle("t1_cyc10_eof",  1'b0, 1'b0, 1'b0, 13'b0_0_0_0_0000_1_0_1_1_0);
    doCycle("t1_cyc11_done", 1'b0, 1'b0, 1'b0, 13'b0_0_0_0_0000_0_0_0_0_1);
    doCycle("t1_cyc12_idle", 1'b0, 1'b0, 1'b0, 13'b0_0_0_0_0000_0_0_0_0_0);

    // Frame of 20: FIFO fills to DEPTH, then streams through.
    wr_base = wr_count;
    rd_base = rd_count;
    applyStimulus(20, 1'b1);
    tick();
    start    = 1'b0;
    sc_valid = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    #1;
    checkOutput("t2_occ_full", 32'(occupancy), 32'd8);
    checkOutput("t2_sc_ready_full", 32'(sc_ready), 32'd0);
    checkOutput("t2_wr_before_drain", 32'(wr_count - wr_base), 32'd8);
    tick();
    layer_valid = 1'b1;
    waitDone("t2_done", 100);
    checkOutput("t2_wr_total", 32'(wr_count - wr_base), 32'd20);
    checkOutput("t2_rd_total", 32'(rd_count - rd_base), 32'd20);
    checkOutput("t2_beats_drained", 32'(exp_q.size()), 32'd0);
    sc_valid    = 1'b0;
    layer_valid = 1'b0;

    // Frame of 6: layer waiting, shortcut late; no write-to-read bypass.
    wr_base = wr_count;
    rd_base = rd_count;
    applyStimulus(6, 1'b1);
    layer_valid = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("t3_no_rd_when_empty", 32'({layer_ready, fifo_rd_en, occupancy}), 32'd0);
      tick();
    end
    sc_valid = 1'b1;
    #1;
    checkOutput("t3_first_wr_no_bypass", 32'({fifo_wr_en, fifo_rd_en}), 32'b10);
    tick();
    #1;
    checkOutput("t3_rd_after_wr", 32'(fifo_rd_en), 32'd1);
    tick();
    waitDone("t3_done", 100);
    checkOutput("t3_wr_total", 32'(wr_count - wr_base), 32'd6);
    checkOutput("t3_rd_total", 32'(rd_count - rd_base), 32'd6);
    sc_valid    = 1'b0;
    layer_valid = 1'b0;

    // Frame of 1: sof and eof on the same beat.
    out_base = out_count;
    applyStimulus(1, 1'b1);
    sc_valid    = 1'b1;
    layer_valid = 1'b1;
    tick();
    start = 1'b0;
    waitDone("t4_done", 50);
    checkOutput("t4_single_beat", 32'(out_count - out_base), 32'd1);
    sc_valid    = 1'b0;
    layer_valid = 1'b0;

    // Frame of 10 aborted by reset after 5 issues, then a clean frame of 3.
    applyStimulus(10, 1'b1);
    sc_valid    = 1'b1;
    layer_valid = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (fifo_rd_en) n++;
      if (n == 5) break;
      tick();
    end
    checkOutput("t5_five_issues", 32'(n), 32'd5);
    tick();
    rst_n = 1'b0;
    exp_q.delete();
    exp_done_total--;
    #1;
    checkOutput("t5_outputs_in_reset", 32'(obs), 32'd0);
    tick();
    tick();
    rst_n       = 1'b1;
    sc_valid    = 1'b0;
    layer_valid = 1'b0;
    #1;
    checkOutput("t5_idle_after_reset", 32'({busy, done}), 32'd0);
    tick();
    tick();
    applyStimulus(3, 1'b1);
    sc_valid    = 1'b1;
    layer_valid = 1'b1;
    tick();
    start = 1'b0;
    waitDone("t5_restart_done", 50);
    sc_valid    = 1'b0;
    layer_valid = 1'b0;

    // Zero-length start ignored; start during RUN ignored.
    applyStimulus(0, 1'b0);
    tick();
    start = 1'b0;
    #1;
    checkOutput("t6_zero_len_ignored", 32'(busy), 32'd0);
    tick();
    out_base = out_count;
    applyStimulus(5, 1'b1);
    tick();
    start       = 1'b0;
    sc_valid    = 1'b1;
    layer_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    start     = 1'b1;
    frame_len = LEN_W'(9);
    tick();
    start = 1'b0;
    waitDone("t6_done", 100);
    sc_valid    = 1'b0;
    layer_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checkOutput("t6_five_beats", 32'(out_count - out_base), 32'd5);
    checkOutput("total_dones", 32'(done_seen), 32'(exp_done_total));
    checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("max_occupancy", 32'(max_occ), 32'(DEPTH));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
